// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ROB ids at dispatch, captures CDB results,
// retires strictly in program order and flags branch mispredictions at commit.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int ID_W      = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            alloc_valid,
  input  logic [4:0]      alloc_rd,
  input  logic            alloc_is_branch,
  input  logic            alloc_is_store,
  input  logic            alloc_pred_taken,
  output logic [ID_W-1:0] alloc_rob_id,
  output logic            rob_full,
  input  logic [ID_W-1:0] query1_id,
  input  logic [ID_W-1:0] query2_id,
  output logic            query1_ready,
  output logic            query2_ready,
  output logic [31:0]     query1_value,
  output logic [31:0]     query2_value,
  input  logic            alu_valid,
  input  logic [ID_W-1:0] alu_rob_id,
  input  logic [31:0]     alu_value,
  input  logic            alu_taken,
  input  logic            lsb_valid,
  input  logic [ID_W-1:0] lsb_rob_id,
  input  logic [31:0]     lsb_value,
  output logic            commit_flag,
  output logic [4:0]      commit_rd,
  output logic [ID_W-1:0] commit_rob_id,
  output logic [31:0]     commit_value,
  output logic            commit_store_flag,
  output logic            rollback_flag,
  output logic [31:0]     rollback_pc
);

  localparam int IDX_W  = $clog2(ROB_DEPTH);
  localparam int CNT_W  = $clog2(ROB_DEPTH + 1);
  localparam int DATA_W = 32;

  logic [IDX_W-1:0]     head, tail;
  logic [CNT_W-1:0]     count;
  logic [ROB_DEPTH-1:0] busy, ready;
  logic [ROB_DEPTH-1:0] is_branch, is_store, pred_taken, taken;
  logic [4:0]           rd_q    [ROB_DEPTH];
  logic [DATA_W-1:0]    value_q [ROB_DEPTH];
  // Set by a mispredicted commit; the flush happens on the next enabled edge.
  logic                 rollback_pend;

  logic             do_alloc, do_commit, alu_hit, lsb_hit;
  logic [IDX_W-1:0] alu_idx, lsb_idx;
  logic [ID_W-1:0]  head_id;

  function automatic logic id_ok(input logic [ID_W-1:0] id);
    return (id != '0) && (id <= ID_W'(ROB_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] id_to_idx(input logic [ID_W-1:0] id);
    logic [ID_W-1:0] t;
    t = id - ID_W'(1);
    return t[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(ROB_DEPTH - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  // CDB bypass takes priority over the stored entry; ALU before LSB.
  function automatic logic [DATA_W:0] lookup(input logic [ID_W-1:0] qid);
    logic [IDX_W-1:0] qi;
    lookup = '0;
    qi     = id_to_idx(qid);
    if (id_ok(qid)) begin
      if (alu_valid && alu_rob_id == qid)      lookup = {1'b1, alu_value};
      else if (lsb_valid && lsb_rob_id == qid) lookup = {1'b1, lsb_value};
      else if (busy[qi] && ready[qi])          lookup = {1'b1, value_q[qi]};
    end
  endfunction

  assign alloc_rob_id = ID_W'(tail) + ID_W'(1);
  assign head_id      = ID_W'(head) + ID_W'(1);
  assign rob_full     = (count == CNT_W'(ROB_DEPTH));
  assign alu_idx      = id_to_idx(alu_rob_id);
  assign lsb_idx      = id_to_idx(lsb_rob_id);
  assign alu_hit      = alu_valid && id_ok(alu_rob_id) && busy[alu_idx];
  assign lsb_hit      = lsb_valid && id_ok(lsb_rob_id) && busy[lsb_idx];
  assign do_alloc     = rdy && !rollback_pend && alloc_valid && !rob_full;
  assign do_commit    = rdy && !rollback_pend && (count != '0) && ready[head];

  always_comb begin
    {query1_ready, query1_value} = lookup(query1_id);
    {query2_ready, query2_value} = lookup(query2_id);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      busy              <= '0;
      ready             <= '0;
      rollback_pend     <= 1'b0;
      commit_flag       <= 1'b0;
      commit_store_flag <= 1'b0;
      rollback_flag     <= 1'b0;
      commit_rd         <= '0;
      commit_rob_id     <= '0;
      commit_value      <= '0;
      rollback_pc       <= '0;
    end else if (!rdy) begin
      commit_flag       <= 1'b0;
      commit_store_flag <= 1'b0;
      rollback_flag     <= 1'b0;
    end else if (rollback_pend) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      busy              <= '0;
      ready             <= '0;
      rollback_pend     <= 1'b0;
      commit_flag       <= 1'b0;
      commit_store_flag <= 1'b0;
      rollback_flag     <= 1'b0;
    end else begin
      commit_flag       <= 1'b0;
      commit_store_flag <= 1'b0;
      rollback_flag     <= 1'b0;
      if (do_alloc) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= next_ptr(tail);
      end
      if (lsb_hit) ready[lsb_idx] <= 1'b1;
      if (alu_hit) ready[alu_idx] <= 1'b1;
      if (do_commit) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= next_ptr(head);
        if (is_store[head]) begin
          commit_store_flag <= 1'b1;
          commit_rob_id     <= head_id;
        end else if (is_branch[head]) begin
          if (taken[head] != pred_taken[head]) begin
            rollback_flag <= 1'b1;
            rollback_pc   <= value_q[head];
            rollback_pend <= 1'b1;
          end
        end else if (rd_q[head] != 5'd0) begin
          commit_flag   <= 1'b1;
          commit_rd     <= rd_q[head];
          commit_rob_id <= head_id;
          commit_value  <= value_q[head];
        end
      end
      count <= count + CNT_W'(do_alloc) - CNT_W'(do_commit);
    end
  end

  // Entry payload; validity is carried entirely by busy/ready above.
  always_ff @(posedge clk) begin
    if (rdy && !rollback_pend) begin
      if (do_alloc) begin
        rd_q[tail]       <= alloc_rd;
        is_branch[tail]  <= alloc_is_branch;
        is_store[tail]   <= alloc_is_store;
        pred_taken[tail] <= alloc_pred_taken;
        taken[tail]      <= 1'b0;
      end
      if (lsb_hit) value_q[lsb_idx] <= lsb_value;
      if (alu_hit) begin
        value_q[alu_idx] <= alu_value;
        taken[alu_idx]   <= alu_taken;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic, all
// checked every cycle against a program-order queue model of the ROB.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        alloc_valid, alloc_is_branch, alloc_is_store, alloc_pred_taken;
  logic [4:0]  alloc_rd;
  logic [4:0]  alloc_rob_id;
  logic        rob_full;
  logic [4:0]  query1_id, query2_id;
  logic        query1_ready, query2_ready;
  logic [31:0] query1_value, query2_value;
  logic        alu_valid, alu_taken, lsb_valid;
  logic [4:0]  alu_rob_id, lsb_rob_id;
  logic [31:0] alu_value, lsb_value;
  logic        commit_flag, commit_store_flag, rollback_flag;
  logic [4:0]  commit_rd, commit_rob_id;
  logic [31:0] commit_value, rollback_pc;

  reorder_buffer #(.ROB_DEPTH(16), .ID_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_is_branch(alloc_is_branch), .alloc_is_store(alloc_is_store),
    .alloc_pred_taken(alloc_pred_taken),
    .alloc_rob_id(alloc_rob_id), .rob_full(rob_full),
    .query1_id(query1_id), .query2_id(query2_id),
    .query1_ready(query1_ready), .query2_ready(query2_ready),
    .query1_value(query1_value), .query2_value(query2_value),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value), .alu_taken(alu_taken),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .commit_flag(commit_flag), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
    .commit_value(commit_value), .commit_store_flag(commit_store_flag),
    .rollback_flag(rollback_flag), .rollback_pc(rollback_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_cf   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions in program order.
  typedef struct {
    int          id;
    logic [4:0]  rd;
    bit          br, st, pred, taken, done;
    logic [31:0] val;
  } ent_t;

  ent_t        m_rob[$];
  int          m_next = 1;
  bit          m_pend = 0;
  logic        e_cf = 0, e_csf = 0, e_rb = 0;
  logic [4:0]  e_crd = 0, e_cid = 0;
  logic [31:0] e_cval = 0, e_rbpc = 0;

  task automatic model_query(input logic [4:0] q, output bit r, output logic [31:0] v);
    r = 0;
    v = 0;
    if (q == 0) return;
    if (alu_valid && alu_rob_id == q) begin r = 1; v = alu_value; return; end
    if (lsb_valid && lsb_rob_id == q) begin r = 1; v = lsb_value; return; end
    foreach (m_rob[i]) if (m_rob[i].id == q && m_rob[i].done) begin r = 1; v = m_rob[i].val; end
  endtask

  task automatic model_step();
    bit   com, full;
    ent_t h, n;
    if (rst) begin
      m_rob.delete(); m_next = 1; m_pend = 0;
      e_cf = 0; e_csf = 0; e_rb = 0; e_crd = 0; e_cid = 0; e_cval = 0; e_rbpc = 0;
      return;
    end
    e_cf = 0; e_csf = 0; e_rb = 0;
    if (!rdy) return;
    if (m_pend) begin
      m_rob.delete(); m_next = 1; m_pend = 0;
      return;
    end
    com  = (m_rob.size() > 0) && m_rob[0].done;
    full = (m_rob.size() == 16);
    foreach (m_rob[i]) begin
      if (lsb_valid && lsb_rob_id == m_rob[i].id) begin
        m_rob[i].done = 1; m_rob[i].val = lsb_value;
      end
      if (alu_valid && alu_rob_id == m_rob[i].id) begin
        m_rob[i].done = 1; m_rob[i].val = alu_value; m_rob[i].taken = alu_taken;
      end
    end
    if (com) begin
      h = m_rob.pop_front();
      if (h.st) begin
        e_csf = 1; e_cid = 5'(h.id);
      end else if (h.br) begin
        if (h.taken != h.pred) begin e_rb = 1; e_rbpc = h.val; m_pend = 1; end
      end else if (h.rd != 0) begin
        e_cf = 1; e_crd = h.rd; e_cid = 5'(h.id); e_cval = h.val;
      end
    end
    if (alloc_valid && !full) begin
      n.id = m_next; n.rd = alloc_rd; n.br = alloc_is_branch; n.st = alloc_is_store;
      n.pred = alloc_pred_taken; n.taken = 0; n.done = 0; n.val = 0;
      m_rob.push_back(n);
      m_next = (m_next == 16) ? 1 : m_next + 1;
    end
  endtask

  task automatic check_comb();
    bit          r;
    logic [31:0] v;
    chk("alloc_rob_id", 32'(alloc_rob_id), 32'(m_next));
    chk("rob_full", 32'(rob_full), 32'(m_rob.size() == 16));
    model_query(query1_id, r, v);
    chk("query1_ready", 32'(query1_ready), 32'(r));
    if (r || query1_id == 0) chk("query1_value", query1_value, v);
    model_query(query2_id, r, v);
    chk("query2_ready", 32'(query2_ready), 32'(r));
    if (r || query2_id == 0) chk("query2_value", query2_value, v);
  endtask

  task automatic check_regs();
    if (commit_flag === 1'b1) n_cf++;
    chk("commit_flag", 32'(commit_flag), 32'(e_cf));
    chk("commit_store_flag", 32'(commit_store_flag), 32'(e_csf));
    chk("rollback_flag", 32'(rollback_flag), 32'(e_rb));
    chk("commit_rd", 32'(commit_rd), 32'(e_crd));
    chk("commit_rob_id", 32'(commit_rob_id), 32'(e_cid));
    chk("commit_value", commit_value, e_cval);
    chk("rollback_pc", rollback_pc, e_rbpc);
  endtask

  // Inputs are set at the falling edge; this advances one clock.
  task automatic tick();
    #1;
    check_comb();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic set_idle();
    rst = 0; rdy = 1;
    alloc_valid = 0; alloc_rd = 0; alloc_is_branch = 0; alloc_is_store = 0; alloc_pred_taken = 0;
    query1_id = 0; query2_id = 0;
    alu_valid = 0; alu_rob_id = 0; alu_value = 0; alu_taken = 0;
    lsb_valid = 0; lsb_rob_id = 0; lsb_value = 0;
  endtask

  task automatic do_reset();
    set_idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic alloc_op(input logic [4:0] rd, input bit br, input bit st, input bit pred);
    alloc_valid = 1; alloc_rd = rd; alloc_is_branch = br; alloc_is_store = st; alloc_pred_taken = pred;
  endtask

  task automatic alu_op(input logic [4:0] id, input logic [31:0] v, input bit tk);
    alu_valid = 1; alu_rob_id = id; alu_value = v; alu_taken = tk;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin set_idle(); tick(); end
  endtask

  task automatic random_cycle();
    int cand[$];
    int a, b, k;
    set_idle();
    rdy = ($urandom_range(0, 9) != 0);
    rst = ($urandom_range(0, 299) == 0);
    if ($urandom_range(0, 9) < 6) begin
      k = $urandom_range(0, 19);
      alloc_op(5'($urandom_range(0, 31)), k >= 3 && k < 7, k < 3, 1'($urandom_range(0, 1)));
    end
    foreach (m_rob[i]) if (!m_rob[i].done) cand.push_back(i);
    a = -1;
    if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
      a = cand[$urandom_range(0, cand.size() - 1)];
      alu_op(5'(m_rob[a].id), $urandom, m_rob[a].pred ^ ($urandom_range(0, 4) == 0));
    end else if ($urandom_range(0, 7) == 0) begin
      alu_op(5'd0, $urandom, 1'b0);
    end
    if (cand.size() > 1 && $urandom_range(0, 2) == 0) begin
      b = cand[$urandom_range(0, cand.size() - 1)];
      if (b != a) begin
        lsb_valid = 1; lsb_rob_id = 5'(m_rob[b].id); lsb_value = $urandom;
      end
    end
    query1_id = 5'($urandom_range(0, 16));
    query2_id = (alu_valid && $urandom_range(0, 1) == 1) ? alu_rob_id : 5'($urandom_range(0, 16));
  endtask

  int base;

  initial begin
    set_idle();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check_regs();
    rst = 0;

    // Idle after reset
    idle(10);

    // Single writeback then commit
    base = n_cf;
    set_idle(); alloc_op(5'd5, 0, 0, 0); tick();
    set_idle(); alu_op(5'd1, 32'h1234, 0); tick();
    idle(4);
    chk("single_commit_count", 32'(n_cf - base), 32'd1);
    chk("single_commit_value", commit_value, 32'h1234);

    // Out-of-order completion, in-order retire
    do_reset();
    for (int i = 1; i <= 3; i++) begin set_idle(); alloc_op(5'(i), 0, 0, 0); tick(); end
    for (int i = 3; i >= 1; i--) begin set_idle(); alu_op(5'(i), 32'(i * 100), 0); tick(); end
    idle(4);
    chk("ooo_last_id", 32'(commit_rob_id), 32'd3);

    // Fill, overflow attempt, drain one
    do_reset();
    for (int i = 0; i < 17; i++) begin set_idle(); alloc_op(5'(i + 1), 0, 0, 0); tick(); end
    chk("full_after_fill", 32'(rob_full), 32'd1);
    chk("wrap_next_id", 32'(alloc_rob_id), 32'd1);
    set_idle(); alu_op(5'd1, 32'hABCD, 0); tick();
    idle(2);
    chk("not_full_after_commit", 32'(rob_full), 32'd0);

    // Branch misprediction with ready younger entries
    do_reset();
    set_idle(); alloc_op(5'd0, 1, 0, 0); tick();
    set_idle(); alloc_op(5'd7, 0, 0, 0); tick();
    set_idle(); alloc_op(5'd8, 0, 0, 0); alu_op(5'd2, 32'd5, 0); tick();
    set_idle(); alu_op(5'd3, 32'd6, 0); tick();
    base = n_cf;
    set_idle(); alu_op(5'd1, 32'h80, 1); tick();
    idle(4);
    chk("rollback_pc_value", rollback_pc, 32'h80);
    chk("younger_not_committed", 32'(n_cf - base), 32'd0);
    chk("empty_after_rollback", 32'(alloc_rob_id), 32'd1);

    // CDB bypass on query, then rdy stall
    set_idle(); alloc_op(5'd9, 0, 0, 0); tick();
    set_idle(); alloc_op(5'd10, 0, 0, 0); tick();
    set_idle(); query1_id = 5'd2; alu_op(5'd2, 32'd7, 0);
    #1;
    chk("bypass_ready", 32'(query1_ready), 32'd1);
    chk("bypass_value", query1_value, 32'd7);
    tick();
    for (int i = 0; i < 3; i++) begin set_idle(); rdy = 0; alu_op(5'd1, 32'd3, 0); alloc_op(5'd4, 0, 0, 0); tick(); end
    idle(4);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) random_cycle_and_tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic random_cycle_and_tick();
    random_cycle();
    tick();
  endtask

endmodule
